shift_reg_multi: RTL and testbench
==================================

// Module: shift_reg_multi
// PURPOSE
//  General-purpose datapath register: the next generation of the single-bit
//  shift/count register. Adds multi-bit shifts executed one bit per clock
//  under a start/busy/done handshake, rotate and arithmetic modes, a
//  carry/borrow flag and a zero flag.
//  Used for CPU accumulator/shift operands, driven by the control unit.
// PARAMETERS
//  DATA_WIDTH   16   register width in bits; must be >= 2
//  RESET_VALUE  0    value loaded into out on rst_n assertion
//  (local) AMT_W = $clog2(DATA_WIDTH)+1   width of the amt port
// PORTS
//  clk    in   1          clock, rising edge
//  rst_n  in   1          asynchronous reset, active low
//  cl     in   1          clear out to 0 (highest priority; also aborts a shift)
//  ld     in   1          load in
//  in     in   DATA_WIDTH parallel load data
//  inc    in   1          increment
//  dec    in   1          decrement
//  start  in   1          begin a shift of amt bits
//  dir    in   1          0 = right, 1 = left; sampled with start
//  mode   in   2          00 logical, 01 rotate, 10 arithmetic, 11 serial-in; sampled with start
//  amt    in   AMT_W      shift count; values > DATA_WIDTH clamp to DATA_WIDTH
//  ir     in   1          serial input for right shifts in mode 11
//  il     in   1          serial input for left shifts in mode 11
//  out    out  DATA_WIDTH register contents
//  busy   out  1          multi-cycle shift in progress
//  done   out  1          one-cycle pulse: shift finished
//  co     out  1          carry/borrow/last-shifted-out bit
//  zero   out  1          combinational: out == 0
// BEHAVIOUR
//  Reset: out=RESET_VALUE, busy=0, done=0, co=0, state=IDLE, cnt=0.
//  FSM: IDLE, SHIFT. done defaults to 0 every cycle.
//  IDLE priority: cl > ld > start > inc > dec.
//   cl: out<=0, co<=0.  ld: out<=in, co<=0.
//   inc: out<=out+1; co<=1 iff out was all-ones (wraps to 0), else 0.
//   dec: out<=out-1; co<=1 iff out was 0 (wraps to all-ones), else 0.
//   start, clamped amt==0: no shift, out/co unchanged, done=1 next cycle, stay IDLE.
//   start, amt>0: latch dir/mode, cnt<=clamp(amt), busy<=1, go SHIFT; out unchanged.
//  SHIFT, per cycle: one 1-bit step on out, cnt<=cnt-1, co<=bit shifted out.
//   Right: logical fills MSB with 0; rotate fills MSB with old LSB;
//          arithmetic fills MSB with old MSB; serial-in fills MSB with ir.
//   Left:  logical and arithmetic fill LSB with 0; rotate fills LSB with old MSB;
//          serial-in fills LSB with il.
//   Step with cnt==1: go IDLE; busy<=0 and done<=1 on the same edge.
//   Latency: start sampled at edge k; steps at edges k+1..k+N.
//            busy high between edges k and k+N; done high one cycle after edge k+N.
//   cl during SHIFT: out<=0, co<=0, busy<=0, go IDLE, no done pulse.
//   ld/inc/dec/start during SHIFT are ignored (not queued).
//   ir/il are sampled on every step (live serial stream).
//  rst_n low at any time (including mid-shift): immediate return to reset values.
// CONFIGURATION
//  SHIFT_REG_SAT_EN defined: inc/dec saturate.
//   inc at all-ones holds all-ones with co<=1; dec at 0 holds 0 with co<=1.
//  Undefined: inc/dec wrap modulo 2^DATA_WIDTH as described above. Shifts unaffected.
// TESTING (DATA_WIDTH=16)
//  Reset mid-shift: rst_n low while busy -> out=RESET_VALUE, busy=0, done=0, co=0 at once.
//  ld 16'h8001; start dir=0 mode=10 amt=3
//   -> out 16'hF000 after 3 cycles, co=0, busy 3 cycles, done one pulse.
//  ld 16'h8001; start dir=1 mode=01 amt=20 (clamp 16)
//   -> busy 16 cycles; out=16'h8001; co=1 (last bit out = old MSB 1).
//  ld 16'hFFFF; inc -> out=0, co=1, zero=1 (SAT_EN: out=16'hFFFF, co=1).
//   Then from 0: dec -> out=16'hFFFF, co=1 (SAT_EN: out=0, co=1).
//  start amt=5, cl after 2 steps -> out=0, busy=0, no done.
//   A simultaneous inc during SHIFT is ignored.
//  start amt=0 -> done pulse 1 cycle later, busy never set, out unchanged.
//   Then mode=11 dir=0 amt=4 with ir=1 from 0 -> out=16'hF000.

Source files
------------

// File: rtl/shift_reg_multi_if.sv
// Command/status bundle between the control unit (master) and shift_reg_multi (slave).
// Parameter DATA_WIDTH sets the data width; amt width is derived from it.
interface shift_reg_multi_if #(
  parameter int DATA_WIDTH = 16
);
  localparam int AMT_W = $clog2(DATA_WIDTH) + 1;

  logic                  cl;
  logic                  ld;
  logic [DATA_WIDTH-1:0] in;
  logic                  inc;
  logic                  dec;
  logic                  start;
  logic                  dir;
  logic [1:0]            mode;
  logic [AMT_W-1:0]      amt;
  logic                  ir;
  logic                  il;
  logic [DATA_WIDTH-1:0] out;
  logic                  busy;
  logic                  done;
  logic                  co;
  logic                  zero;

  modport master (
    output cl, ld, in, inc, dec, start, dir, mode, amt, ir, il,
    input  out, busy, done, co, zero
  );

  modport slave (
    input  cl, ld, in, inc, dec, start, dir, mode, amt, ir, il,
    output out, busy, done, co, zero
  );
endinterface

// File: rtl/shift_reg_multi.sv
// Datapath register: load/clear/inc/dec plus multi-bit shifts stepped one bit per clock.
// Define SHIFT_REG_SAT_EN to make inc/dec saturate instead of wrapping.
//
// state | meaning
// IDLE  | accepts cl/ld/start/inc/dec, one command per cycle
// SHIFT | stepping a latched shift, cnt_q steps remaining
module shift_reg_multi #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              clk,
  input logic              rst_n,
  shift_reg_multi_if.slave bus
);
  localparam int AMT_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  co_q;
  logic                  dir_q;
  logic [1:0]            mode_q;
  logic [AMT_W-1:0]      cnt_q;

  logic [AMT_W-1:0]      amt_clamped;
  logic                  fill;
  logic [DATA_WIDTH-1:0] step_val;
  logic                  step_co;
  logic [DATA_WIDTH-1:0] inc_val;
  logic                  inc_co;
  logic [DATA_WIDTH-1:0] dec_val;
  logic                  dec_co;

  assign amt_clamped = (bus.amt > AMT_W'(DATA_WIDTH)) ? AMT_W'(DATA_WIDTH) : bus.amt;

  // One-bit step using the direction/mode latched at start; ir/il are live.
  always_comb begin
    fill     = 1'b0;
    step_val = out_q;
    step_co  = 1'b0;
    if (dir_q) begin
      case (mode_q)
        2'b01:   fill = out_q[DATA_WIDTH-1];
        2'b11:   fill = bus.il;
        default: fill = 1'b0;
      endcase
      step_val = {out_q[DATA_WIDTH-2:0], fill};
      step_co  = out_q[DATA_WIDTH-1];
    end else begin
      case (mode_q)
        2'b01:   fill = out_q[0];
        2'b10:   fill = out_q[DATA_WIDTH-1];
        2'b11:   fill = bus.ir;
        default: fill = 1'b0;
      endcase
      step_val = {fill, out_q[DATA_WIDTH-1:1]};
      step_co  = out_q[0];
    end
  end

  always_comb begin
    inc_val = out_q + DATA_WIDTH'(1);
    inc_co  = (out_q == '1);
    dec_val = out_q - DATA_WIDTH'(1);
    dec_co  = (out_q == '0);
`ifdef SHIFT_REG_SAT_EN
    if (inc_co) inc_val = out_q;
    if (dec_co) dec_val = out_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      out_q  <= RESET_VALUE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      co_q   <= 1'b0;
      dir_q  <= 1'b0;
      mode_q <= 2'b00;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cl) begin
            out_q <= '0;
            co_q  <= 1'b0;
          end else if (bus.ld) begin
            out_q <= bus.in;
            co_q  <= 1'b0;
          end else if (bus.start) begin
            if (amt_clamped == '0) begin
              done_q <= 1'b1;
            end else begin
              dir_q  <= bus.dir;
              mode_q <= bus.mode;
              cnt_q  <= amt_clamped;
              busy_q <= 1'b1;
              state  <= SHIFT;
            end
          end else if (bus.inc) begin
            out_q <= inc_val;
            co_q  <= inc_co;
          end else if (bus.dec) begin
            out_q <= dec_val;
            co_q  <= dec_co;
          end
        end
        SHIFT: begin
          // Abort: no done pulse, other commands are dropped rather than queued.
          if (bus.cl) begin
            out_q  <= '0;
            co_q   <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            state  <= IDLE;
          end else begin
            out_q <= step_val;
            co_q  <= step_co;
            cnt_q <= cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.co   = co_q;
  assign bus.zero = (out_q == '0);
endmodule

// File: tb/tb_shift_reg_multi.sv
// Bench for shift_reg_multi: directed vector table, hand-written corner sequences,
// and random ops checked against an arithmetic reference model.
module tb_shift_reg_multi;
  localparam int W  = 16;
  localparam int AW = $clog2(W) + 1;
  localparam logic [W-1:0] RV = 16'h0000;
  localparam int K_SHIFT = 0;
  localparam int K_INC   = 1;
  localparam int K_DEC   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  shift_reg_multi_if #(.DATA_WIDTH(W)) bus ();

  shift_reg_multi #(.DATA_WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    int         kind;
    logic [W-1:0] ld_val;
    bit         d;
    logic [1:0] m;
    int         a;
    bit         sir;
    bit         sil;
    logic [W-1:0] exp_out;
    bit         exp_co;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result of an n-step shift (1 <= n <= W) computed in one go.
  function automatic void ref_shift(logic [W-1:0] v, bit d, logic [1:0] m, int n, bit sir, bit sil,
                                    output logic [W-1:0] r, output bit c);
    longint unsigned x, mask, top_n, res;
    x     = 64'(v);
    mask  = (64'd1 << W) - 1;
    top_n = mask & ~(mask >> n);
    res   = 0;
    if (!d) begin
      c = v[n-1];
      case (m)
        2'b00: res = x >> n;
        2'b01: res = ((x >> n) | (x << (W - n))) & mask;
        2'b10: res = v[W-1] ? ((x >> n) | top_n) : (x >> n);
        default: res = sir ? ((x >> n) | top_n) : (x >> n);
      endcase
    end else begin
      c = v[W-n];
      case (m)
        2'b01: res = ((x << n) | (x >> (W - n))) & mask;
        2'b11: res = ((x << n) & mask) | (sil ? ((64'd1 << n) - 1) : 64'd0);
        default: res = (x << n) & mask;
      endcase
    end
    r = W'(res);
  endfunction

  function automatic void ref_incdec(bit is_dec, logic [W-1:0] v, output logic [W-1:0] r, output bit c);
    longint unsigned x, top;
    x   = 64'(v);
    top = (64'd1 << W) - 1;
    if (!is_dec) begin
      c = (x == top);
`ifdef SHIFT_REG_SAT_EN
      r = c ? v : W'(x + 1);
`else
      r = W'((x + 1) % (top + 1));
`endif
    end else begin
      c = (x == 0);
`ifdef SHIFT_REG_SAT_EN
      r = c ? v : W'(x - 1);
`else
      r = c ? W'(top) : W'(x - 1);
`endif
    end
  endfunction

  task automatic idle_inputs();
    bus.cl = 1'b0; bus.ld = 1'b0; bus.in = '0; bus.inc = 1'b0; bus.dec = 1'b0;
    bus.start = 1'b0; bus.dir = 1'b0; bus.mode = 2'b00; bus.amt = '0;
    bus.ir = 1'b0; bus.il = 1'b0;
  endtask

  task automatic load(logic [W-1:0] v);
    bus.ld = 1'b1;
    bus.in = v;
    tick();
    bus.ld = 1'b0;
    chk("load_out", 32'(bus.out), 32'(v));
    chk("load_co", 32'(bus.co), 32'd0);
  endtask

  // Start a shift, then count cycles with busy high until it drops (bounded).
  task automatic run_shift(bit d, logic [1:0] m, int a, bit sir, bit sil, output int cyc, output bit dn);
    bus.start = 1'b1; bus.dir = d; bus.mode = m; bus.amt = AW'(a);
    bus.ir = sir; bus.il = sil;
    tick();
    bus.start = 1'b0; bus.dir = ~d; bus.mode = ~m; bus.amt = '0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
    dn = bus.done;
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  task automatic apply_op(int kind, logic [W-1:0] v, bit d, logic [1:0] m, int a, bit sir, bit sil,
                          output int cyc, output bit dn);
    load(v);
    cyc = 0;
    dn  = 1'b0;
    case (kind)
      K_INC: begin bus.inc = 1'b1; tick(); bus.inc = 1'b0; end
      K_DEC: begin bus.dec = 1'b1; tick(); bus.dec = 1'b0; end
      default: run_shift(d, m, a, sir, sil, cyc, dn);
    endcase
  endtask

  initial begin
    int         cyc;
    bit         dn;
    logic [W-1:0] eo;
    bit         ec;
    idle_inputs();

    vecs[0]  = '{K_SHIFT, 16'h8001, 1'b0, 2'b10, 3,  1'b0, 1'b0, 16'hF000, 1'b0, 3};
    vecs[1]  = '{K_SHIFT, 16'h8001, 1'b1, 2'b01, 20, 1'b0, 1'b0, 16'h8001, 1'b1, 16};
`ifdef SHIFT_REG_SAT_EN
    vecs[2]  = '{K_INC,   16'hFFFF, 1'b0, 2'b00, 0,  1'b0, 1'b0, 16'hFFFF, 1'b1, 0};
    vecs[3]  = '{K_DEC,   16'h0000, 1'b0, 2'b00, 0,  1'b0, 1'b0, 16'h0000, 1'b1, 0};
`else
    vecs[2]  = '{K_INC,   16'hFFFF, 1'b0, 2'b00, 0,  1'b0, 1'b0, 16'h0000, 1'b1, 0};
    vecs[3]  = '{K_DEC,   16'h0000, 1'b0, 2'b00, 0,  1'b0, 1'b0, 16'hFFFF, 1'b1, 0};
`endif
    vecs[4]  = '{K_SHIFT, 16'h0000, 1'b0, 2'b11, 4,  1'b1, 1'b0, 16'hF000, 1'b0, 4};
    vecs[5]  = '{K_SHIFT, 16'h1234, 1'b1, 2'b11, 4,  1'b0, 1'b1, 16'h234F, 1'b1, 4};
    vecs[6]  = '{K_SHIFT, 16'h8001, 1'b0, 2'b00, 1,  1'b0, 1'b0, 16'h4000, 1'b1, 1};
    vecs[7]  = '{K_SHIFT, 16'h8001, 1'b1, 2'b10, 16, 1'b0, 1'b0, 16'h0000, 1'b1, 16};
    vecs[8]  = '{K_SHIFT, 16'hA5A5, 1'b0, 2'b01, 0,  1'b0, 1'b0, 16'hA5A5, 1'b0, 0};
    vecs[9]  = '{K_INC,   16'h00FF, 1'b0, 2'b00, 0,  1'b0, 1'b0, 16'h0100, 1'b0, 0};
    vecs[10] = '{K_SHIFT, 16'h8000, 1'b0, 2'b10, 31, 1'b0, 1'b0, 16'hFFFF, 1'b1, 16};
    vecs[11] = '{K_DEC,   16'h0100, 1'b0, 2'b00, 0,  1'b0, 1'b0, 16'h00FF, 1'b0, 0};

    #12;
    chk("rst_out", 32'(bus.out), 32'(RV));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_co", 32'(bus.co), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'(RV == '0));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      apply_op(vecs[i].kind, vecs[i].ld_val, vecs[i].d, vecs[i].m, vecs[i].a,
               vecs[i].sir, vecs[i].sil, cyc, dn);
      chk($sformatf("vec%0d_out", i), 32'(bus.out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_co", i), 32'(bus.co), 32'(vecs[i].exp_co));
      chk($sformatf("vec%0d_zero", i), 32'(bus.zero), 32'(vecs[i].exp_out == '0));
      if (vecs[i].kind == K_SHIFT) begin
        chk($sformatf("vec%0d_busy_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
        chk($sformatf("vec%0d_done", i), 32'(dn), 32'd1);
      end
    end

    // Asynchronous reset in the middle of a shift.
    load(16'hFFFF);
    bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b00; bus.amt = AW'(10);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out", 32'(bus.out), 32'(RV));
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_co", 32'(bus.co), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // Clear aborts a shift after two steps; inc held high during the shift is ignored.
    load(16'h1237);
    bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b00; bus.amt = AW'(5);
    tick();
    bus.start = 1'b0;
    bus.inc = 1'b1;
    tick();
    tick();
    chk("abort_mid_out", 32'(bus.out), 32'h048D);
    chk("abort_mid_co", 32'(bus.co), 32'd1);
    bus.cl = 1'b1;
    tick();
    bus.cl = 1'b0;
    bus.inc = 1'b0;
    chk("abort_out", 32'(bus.out), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_co", 32'(bus.co), 32'd0);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    tick();
    chk("abort_no_done_late", 32'(bus.done), 32'd0);
    chk("abort_stays_zero", 32'(bus.out), 32'd0);

    // amt=0 keeps out and co from the preceding inc.
    load(16'hFFFF);
    bus.inc = 1'b1;
    tick();
    bus.inc = 1'b0;
    ref_incdec(1'b0, 16'hFFFF, eo, ec);
    run_shift(1'b1, 2'b01, 0, 1'b0, 1'b0, cyc, dn);
    chk("amt0_out", 32'(bus.out), 32'(eo));
    chk("amt0_co", 32'(bus.co), 32'(ec));
    chk("amt0_busy_cycles", 32'(cyc), 32'd0);
    chk("amt0_done", 32'(dn), 32'd1);

    for (int it = 0; it < 80; it++) begin
      logic [W-1:0] v;
      int           kind;
      int           a;
      int           n;
      bit           d;
      bit           sir;
      bit           sil;
      logic [1:0]   m;
      v = W'($urandom);
      if ($urandom_range(0, 5) == 0) v = ($urandom_range(0, 1) == 1) ? {W{1'b1}} : {W{1'b0}};
      kind = $urandom_range(0, 3);
      if (kind == 3) kind = K_SHIFT;
      d   = 1'($urandom_range(0, 1));
      m   = 2'($urandom_range(0, 3));
      a   = $urandom_range(0, 20);
      sir = 1'($urandom_range(0, 1));
      sil = 1'($urandom_range(0, 1));
      n   = (a > W) ? W : a;
      if (kind == K_SHIFT) begin
        if (n == 0) begin
          eo = v;
          ec = 1'b0;
        end else begin
          ref_shift(v, d, m, n, sir, sil, eo, ec);
        end
      end else begin
        ref_incdec(kind == K_DEC, v, eo, ec);
      end
      apply_op(kind, v, d, m, a, sir, sil, cyc, dn);
      chk($sformatf("rnd%0d_out", it), 32'(bus.out), 32'(eo));
      chk($sformatf("rnd%0d_co", it), 32'(bus.co), 32'(ec));
      if (kind == K_SHIFT) begin
        chk($sformatf("rnd%0d_busy_cycles", it), 32'(cyc), 32'(n));
        chk($sformatf("rnd%0d_done", it), 32'(dn), 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
